// File: rtl/bp_axi_lite_master_arbiter.sv
// bp_axi_lite_master_arbiter
// Round-robin arbiter that shares one AXI-Lite master port between num_req_p
// requesters, one outstanding transaction at a time, and routes the B/R
// response back to the requester that was granted.
// Optional response watchdog: define BP_AXIL_ARB_TIMEOUT_EN.
module bp_axi_lite_master_arbiter #(
    parameter int num_req_p         = 2,
    parameter int axi_addr_width_p  = 32,
    parameter int axi_data_width_p  = 64,
    parameter int axi_strb_width_lp = axi_data_width_p / 8,
    parameter int timeout_cycles_p  = 1024
) (
    input  logic                                        clk_i,
    input  logic                                        reset_i,

    input  logic [num_req_p-1:0]                        req_v_i,
    input  logic [num_req_p-1:0]                        req_we_i,
    input  logic [num_req_p*axi_addr_width_p-1:0]       req_addr_i,
    input  logic [num_req_p*axi_data_width_p-1:0]       req_data_i,
    input  logic [num_req_p*axi_strb_width_lp-1:0]      req_strb_i,
    output logic [num_req_p-1:0]                        req_ready_o,

    output logic [num_req_p-1:0]                        resp_v_o,
    output logic [axi_data_width_p-1:0]                 resp_data_o,
    output logic [1:0]                                  resp_err_o,
    input  logic [num_req_p-1:0]                        resp_yumi_i,

    output logic [axi_addr_width_p-1:0]                 m_axi_lite_awaddr_o,
    output logic [2:0]                                  m_axi_lite_awprot_o,
    output logic                                        m_axi_lite_awvalid_o,
    input  logic                                        m_axi_lite_awready_i,
    output logic [axi_data_width_p-1:0]                 m_axi_lite_wdata_o,
    output logic [axi_strb_width_lp-1:0]                m_axi_lite_wstrb_o,
    output logic                                        m_axi_lite_wvalid_o,
    input  logic                                        m_axi_lite_wready_i,
    input  logic [1:0]                                  m_axi_lite_bresp_i,
    input  logic                                        m_axi_lite_bvalid_i,
    output logic                                        m_axi_lite_bready_o,

    output logic [axi_addr_width_p-1:0]                 m_axi_lite_araddr_o,
    output logic [2:0]                                  m_axi_lite_arprot_o,
    output logic                                        m_axi_lite_arvalid_o,
    input  logic                                        m_axi_lite_arready_i,
    input  logic [axi_data_width_p-1:0]                 m_axi_lite_rdata_i,
    input  logic [1:0]                                  m_axi_lite_rresp_i,
    input  logic                                        m_axi_lite_rvalid_i,
    output logic                                        m_axi_lite_rready_o
);

    localparam int unsigned NUM_REQ = num_req_p;
    localparam int unsigned ADDR_W  = axi_addr_width_p;
    localparam int unsigned DATA_W  = axi_data_width_p;
    localparam int unsigned STRB_W  = axi_strb_width_lp;
    localparam int unsigned IDX_W   = (num_req_p > 1) ? $clog2(num_req_p) : 1;

    // Reject unsupported configurations at elaboration.
    if (num_req_p < 2 || num_req_p > 8 || timeout_cycles_p < 2) begin : g_param_check
        $error("bp_axi_lite_master_arbiter: unsupported parameter set");
    end

    typedef enum logic [2:0] {
        e_idle,
        e_write,
        e_b,
        e_ar,
        e_r,
        e_resp,
        e_drain
    } state_e;

    state_e             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   grant;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   cand;
    logic               pick_found;
    logic [NUM_REQ-1:0] pick_oh;
    logic [NUM_REQ-1:0] grant_oh;
    logic               accept;
    logic               we_q;
    logic               aw_done;
    logic               w_done;
    logic               aw_fire;
    logic               w_fire;

`ifdef BP_AXIL_ARB_TIMEOUT_EN
    localparam int unsigned TMR_W = $clog2(timeout_cycles_p);
    logic [TMR_W-1:0]   timer;
    logic               timed_out;
`endif

    // Round-robin pick: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((32'(rr_ptr) + k) % NUM_REQ);
            if (!pick_found && req_v_i[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign pick_oh     = pick_found ? (NUM_REQ'(1) << pick_idx) : '0;
    assign req_ready_o = (state == e_idle) ? pick_oh : '0;
    assign accept      = |(req_v_i & req_ready_o);
    assign grant_oh    = NUM_REQ'(1) << grant;
    assign aw_fire     = m_axi_lite_awvalid_o & m_axi_lite_awready_i;
    assign w_fire      = m_axi_lite_wvalid_o & m_axi_lite_wready_i;

    assign m_axi_lite_awprot_o = 3'b000;
    assign m_axi_lite_arprot_o = 3'b000;

    // Transaction FSM with registered AXI and response outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state                <= e_idle;
            rr_ptr               <= '0;
            grant                <= '0;
            we_q                 <= 1'b0;
            aw_done              <= 1'b0;
            w_done               <= 1'b0;
            m_axi_lite_awaddr_o  <= '0;
            m_axi_lite_awvalid_o <= 1'b0;
            m_axi_lite_wdata_o   <= '0;
            m_axi_lite_wstrb_o   <= '0;
            m_axi_lite_wvalid_o  <= 1'b0;
            m_axi_lite_bready_o  <= 1'b0;
            m_axi_lite_araddr_o  <= '0;
            m_axi_lite_arvalid_o <= 1'b0;
            m_axi_lite_rready_o  <= 1'b0;
            resp_v_o             <= '0;
            resp_data_o          <= '0;
            resp_err_o           <= 2'b00;
`ifdef BP_AXIL_ARB_TIMEOUT_EN
            timer                <= '0;
            timed_out            <= 1'b0;
`endif
        end else begin
            unique case (state)
                e_idle: begin
                    if (accept) begin
                        grant   <= pick_idx;
                        we_q    <= req_we_i[pick_idx];
                        rr_ptr  <= (32'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + IDX_W'(1);
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        if (req_we_i[pick_idx]) begin
                            m_axi_lite_awaddr_o  <= req_addr_i[32'(pick_idx) * ADDR_W +: ADDR_W];
                            m_axi_lite_wdata_o   <= req_data_i[32'(pick_idx) * DATA_W +: DATA_W];
                            m_axi_lite_wstrb_o   <= req_strb_i[32'(pick_idx) * STRB_W +: STRB_W];
                            m_axi_lite_awvalid_o <= 1'b1;
                            m_axi_lite_wvalid_o  <= 1'b1;
                            state                <= e_write;
                        end else begin
                            m_axi_lite_araddr_o  <= req_addr_i[32'(pick_idx) * ADDR_W +: ADDR_W];
                            m_axi_lite_arvalid_o <= 1'b1;
                            state                <= e_ar;
                        end
                    end
                end

                e_write: begin
                    if (aw_fire) begin
                        m_axi_lite_awvalid_o <= 1'b0;
                        aw_done              <= 1'b1;
                    end
                    if (w_fire) begin
                        m_axi_lite_wvalid_o <= 1'b0;
                        w_done              <= 1'b1;
                    end
                    if ((aw_done || aw_fire) && (w_done || w_fire)) begin
                        m_axi_lite_bready_o <= 1'b1;
                        state               <= e_b;
`ifdef BP_AXIL_ARB_TIMEOUT_EN
                        timer               <= '0;
`endif
                    end
                end

                e_b: begin
                    if (m_axi_lite_bvalid_i) begin
                        m_axi_lite_bready_o <= 1'b0;
                        resp_err_o          <= m_axi_lite_bresp_i;
                        resp_data_o         <= '0;
                        resp_v_o            <= grant_oh;
                        state               <= e_resp;
                    end
`ifdef BP_AXIL_ARB_TIMEOUT_EN
                    else if (timer == TMR_W'(timeout_cycles_p - 1)) begin
                        m_axi_lite_bready_o <= 1'b0;
                        resp_err_o          <= 2'b11;
                        resp_data_o         <= '0;
                        resp_v_o            <= grant_oh;
                        timed_out           <= 1'b1;
                        state               <= e_resp;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
`endif
                end

                e_ar: begin
                    if (m_axi_lite_arready_i) begin
                        m_axi_lite_arvalid_o <= 1'b0;
                        m_axi_lite_rready_o  <= 1'b1;
                        state                <= e_r;
`ifdef BP_AXIL_ARB_TIMEOUT_EN
                        timer                <= '0;
`endif
                    end
                end

                e_r: begin
                    if (m_axi_lite_rvalid_i) begin
                        m_axi_lite_rready_o <= 1'b0;
                        resp_err_o          <= m_axi_lite_rresp_i;
                        resp_data_o         <= m_axi_lite_rdata_i;
                        resp_v_o            <= grant_oh;
                        state               <= e_resp;
                    end
`ifdef BP_AXIL_ARB_TIMEOUT_EN
                    else if (timer == TMR_W'(timeout_cycles_p - 1)) begin
                        m_axi_lite_rready_o <= 1'b0;
                        resp_err_o          <= 2'b11;
                        resp_data_o         <= '0;
                        resp_v_o            <= grant_oh;
                        timed_out           <= 1'b1;
                        state               <= e_resp;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
`endif
                end

                e_resp: begin
                    if (resp_yumi_i[grant]) begin
                        resp_v_o <= '0;
                        state    <= e_idle;
`ifdef BP_AXIL_ARB_TIMEOUT_EN
                        if (timed_out) begin
                            timed_out <= 1'b0;
                            if (we_q) begin
                                m_axi_lite_bready_o <= 1'b1;
                            end else begin
                                m_axi_lite_rready_o <= 1'b1;
                            end
                            state <= e_drain;
                        end
`endif
                    end
                end

                e_drain: begin
                    // Swallow the late response of a timed-out transaction.
                    if (we_q ? m_axi_lite_bvalid_i : m_axi_lite_rvalid_i) begin
                        m_axi_lite_bready_o <= 1'b0;
                        m_axi_lite_rready_o <= 1'b0;
                        state               <= e_idle;
                    end
                end

                default: state <= e_idle;
            endcase
        end
    end

endmodule
